// File: rtl/tile_fill_dma.sv
// tile_fill_dma: fill engine for the tile map RAM write port.
// Writes a run of entries with a constant or incrementing tile index and
// shares the RAM write port with CPU writes, which always take priority.
module tile_fill_dma #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 6,
   parameter int LEN_W  = 13
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_wen,
   input  logic [1:0]        cfg_sel,
   input  logic [31:0]       cfg_wdata,
   input  logic              vblank,
   input  logic              cpu_wen,
   input  logic [ADDR_W-1:0] cpu_waddr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  remaining
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT_VB = 2'd1,
      S_RUN     = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   // Longest legal run: one pass over the whole RAM.
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(1) << ADDR_W;

   // Shadow (programmed) registers
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [DATA_W-1:0] val_q, val_d;
   logic              inc_q, inc_d;

   // Working counters of the fill in flight
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] value_q, value_d;
   logic              winc_q, winc_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic              vb_prev_q;

   logic              start_s;
   logic              wait_vb_s;
   logic              abort_s;
   logic [LEN_W-1:0]  len_in_s;
   logic              unused_cfg_bits;

   assign unused_cfg_bits = ^cfg_wdata[31:LEN_W];

   // Config register decode: shadow updates and self-clearing CTRL strobes.
   always_comb begin
      dst_d     = dst_q;
      len_d     = len_q;
      val_d     = val_q;
      inc_d     = inc_q;
      start_s   = 1'b0;
      wait_vb_s = 1'b0;
      abort_s   = 1'b0;
      len_in_s  = cfg_wdata[LEN_W-1:0];
      if (cfg_wen) begin
         case (cfg_sel)
            2'd0: dst_d = cfg_wdata[ADDR_W-1:0];
            2'd1: len_d = (len_in_s > LEN_MAX) ? LEN_MAX : len_in_s;
            2'd2: begin
               val_d = cfg_wdata[DATA_W-1:0];
               inc_d = cfg_wdata[8];
            end
            2'd3: begin
               start_s   = cfg_wdata[0];
               wait_vb_s = cfg_wdata[1];
               abort_s   = cfg_wdata[2];
            end
            default: dst_d = dst_q;
         endcase
      end else begin
         start_s = 1'b0;
      end
   end

   // Fill FSM: next state and working-counter updates; ABORT overrides all.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      value_d = value_q;
      winc_d  = winc_q;
      rem_d   = rem_q;
      if (abort_s) begin
         state_d = S_IDLE;
         rem_d   = {LEN_W{1'b0}};
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_s) begin
                  addr_d  = dst_q;
                  value_d = val_q;
                  winc_d  = inc_q;
                  rem_d   = len_q;
                  if (len_q == {LEN_W{1'b0}}) begin
                     state_d = S_DONE;
                  end else if (wait_vb_s) begin
                     state_d = S_WAIT_VB;
                  end else begin
                     state_d = S_RUN;
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_WAIT_VB: begin
               // Only a fresh rising edge releases the fill.
               if (vblank && !vb_prev_q) begin
                  state_d = S_RUN;
               end else begin
                  state_d = S_WAIT_VB;
               end
            end
            S_RUN: begin
               // A CPU write owns the port this cycle; the fill simply holds.
               if (!cpu_wen) begin
                  addr_d  = addr_q + ADDR_W'(1);
                  value_d = value_q + {{(DATA_W-1){1'b0}}, winc_q};
                  rem_d   = rem_q - LEN_W'(1);
                  if (rem_q == LEN_W'(1)) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_RUN;
                  end
               end else begin
                  state_d = S_RUN;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Write port mux: CPU first, then the fill engine while running.
   always_comb begin
      mem_wen   = 1'b0;
      mem_waddr = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
      if (cpu_wen) begin
         mem_wen   = 1'b1;
         mem_waddr = cpu_waddr;
         mem_wdata = cpu_wdata;
      end else if (state_q == S_RUN) begin
         mem_wen   = 1'b1;
         mem_waddr = addr_q;
         mem_wdata = value_q;
      end else begin
         mem_wen   = 1'b0;
      end
   end

   // State and register update with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         dst_q     <= {ADDR_W{1'b0}};
         len_q     <= {LEN_W{1'b0}};
         val_q     <= {DATA_W{1'b0}};
         inc_q     <= 1'b0;
         state_q   <= S_IDLE;
         addr_q    <= {ADDR_W{1'b0}};
         value_q   <= {DATA_W{1'b0}};
         winc_q    <= 1'b0;
         rem_q     <= {LEN_W{1'b0}};
         vb_prev_q <= 1'b0;
      end else begin
         dst_q     <= dst_d;
         len_q     <= len_d;
         val_q     <= val_d;
         inc_q     <= inc_d;
         state_q   <= state_d;
         addr_q    <= addr_d;
         value_q   <= value_d;
         winc_q    <= winc_d;
         rem_q     <= rem_d;
         vb_prev_q <= vblank;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign remaining = rem_q;

endmodule

// File: tb/tb_tile_fill_dma.sv
// Self-checking bench for tile_fill_dma: table-driven fills, randomized
// CPU contention against a write-list reference model, and hand-written
// sequences for vblank wait, abort, reset and mid-fill rewrites.
module tb_tile_fill_dma;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_wen;
   logic [1:0]  cfg_sel;
   logic [31:0] cfg_wdata;
   logic        vblank;
   logic        cpu_wen;
   logic [11:0] cpu_waddr;
   logic [5:0]  cpu_wdata;
   logic        mem_wen;
   logic [11:0] mem_waddr;
   logic [5:0]  mem_wdata;
   logic        busy;
   logic        done;
   logic [12:0] remaining;

   int total = 0;
   int bad   = 0;
   int got_n;
   logic [11:0] got_last_a;
   logic [5:0]  got_last_d;
   int bc;

   typedef struct {
      logic [11:0] dst;
      logic [31:0] len_raw;
      logic [5:0]  val;
      logic        inc;
      int          exp_n;
      logic [11:0] exp_last_a;
      logic [5:0]  exp_last_d;
      int          exp_busy;
   } vec_t;

   vec_t vecs[6];

   tile_fill_dma dut (
      .clk(clk), .reset(reset),
      .cfg_wen(cfg_wen), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
      .vblank(vblank),
      .cpu_wen(cpu_wen), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
      .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .remaining(remaining)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] sel, input logic [31:0] data);
      cfg_wen   = 1'b1;
      cfg_sel   = sel;
      cfg_wdata = data;
      cyc();
      cfg_wen   = 1'b0;
      cfg_wdata = 32'd0;
   endtask

   // Effective run length from a raw LEN write: low 13 bits, capped at 4096.
   function automatic int eff_len(input logic [31:0] raw);
      int l;
      l = int'(raw % 32'd8192);
      return (l > 4096) ? 4096 : l;
   endfunction

   // Program (optionally), START, then watch the port until busy drops.
   // Fill writes are collected and compared with the expected address/data list.
   task automatic do_fill(input logic [11:0] dst, input logic [31:0] len_raw,
                          input logic [5:0] val, input logic inc,
                          input logic [15:0] cpu_mask, input int cpu_p,
                          input bit mid_cfg, input bit load, output int busy_out);
      logic [17:0] seen[$];
      int L, k, stalls, busy_cnt, done_cnt, nmis;
      bit fin;
      logic [11:0] ea;
      logic [5:0]  ed;
      L = eff_len(len_raw);
      if (load) begin
         cfg_write(2'd0, {20'd0, dst});
         cfg_write(2'd1, len_raw);
         cfg_write(2'd2, {23'd0, inc, 2'd0, val});
      end
      cfg_write(2'd3, 32'd1);
      k = 0; stalls = 0; busy_cnt = 0; done_cnt = 0; fin = 1'b0;
      while (!fin && k < 10000) begin
         cpu_wen   = (k < 16 && cpu_mask[k]) || ($urandom_range(0, 99) < cpu_p);
         cpu_waddr = 12'($urandom);
         cpu_wdata = 6'($urandom);
         if (mid_cfg && k >= 2 && k <= 5) begin
            cfg_wen = 1'b1;
            case (k)
               2: begin cfg_sel = 2'd0; cfg_wdata = 32'h555; end
               3: begin cfg_sel = 2'd1; cfg_wdata = 32'd2;   end
               4: begin cfg_sel = 2'd2; cfg_wdata = 32'h11;  end
               default: begin cfg_sel = 2'd3; cfg_wdata = 32'd1; end
            endcase
         end
         @(negedge clk);
         if (k == 0) begin
            check("busy_after_start", busy, 1);
            check("remaining_at_start", remaining, L);
         end
         if (cpu_wen) begin
            check("cpu_passthru", {mem_wen, mem_waddr, mem_wdata}, {1'b1, cpu_waddr, cpu_wdata});
            if (busy && !done && seen.size() < L) stalls++;
         end else if (mem_wen) begin
            seen.push_back({mem_waddr, mem_wdata});
         end
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         if (!busy) begin
            fin = 1'b1;
            check("idle_no_fill_write", mem_wen, cpu_wen);
         end
         @(posedge clk);
         #1;
         cfg_wen = 1'b0;
         k++;
      end
      cpu_wen = 1'b0;
      check("fill_finished", fin, 1);
      check("write_count", seen.size(), L);
      nmis = 0;
      for (int i = 0; i < seen.size() && i < L; i++) begin
         ea = dst + 12'(i);
         ed = inc ? (val + 6'(i)) : val;
         if (seen[i] !== {ea, ed}) nmis++;
      end
      check("fill_seq_mismatches", nmis, 0);
      check("done_pulses", done_cnt, 1);
      check("busy_cycles", busy_cnt, L + 1 + stalls);
      check("remaining_end", remaining, 0);
      got_n = seen.size();
      if (seen.size() > 0) begin
         got_last_a = seen[$][17:6];
         got_last_d = seen[$][5:0];
      end else begin
         got_last_a = 12'd0;
         got_last_d = 6'd0;
      end
      busy_out = busy_cnt;
   endtask

   initial begin
      vecs[0] = '{12'h010, 32'd4,      6'h05, 1'b0, 4,    12'h013, 6'h05, 5};
      vecs[1] = '{12'hFFE, 32'd4,      6'h3E, 1'b1, 4,    12'h001, 6'h01, 5};
      vecs[2] = '{12'h123, 32'd1,      6'h00, 1'b1, 1,    12'h123, 6'h00, 2};
      vecs[3] = '{12'h800, 32'h1FFF,   6'h3F, 1'b1, 4096, 12'h7FF, 6'h3E, 4097};
      vecs[4] = '{12'hFFF, 32'h10005,  6'h3F, 1'b0, 5,    12'h003, 6'h3F, 6};
      vecs[5] = '{12'h2A0, 32'd0,      6'h15, 1'b1, 0,    12'h000, 6'h00, 1};

      reset = 1'b1; cfg_wen = 1'b0; cfg_sel = 2'd0; cfg_wdata = 32'd0;
      vblank = 1'b0; cpu_wen = 1'b0; cpu_waddr = 12'd0; cpu_wdata = 6'd0;
      cyc(); cyc();
      reset = 1'b0;
      @(negedge clk);
      check("reset_outputs", {busy, done, remaining, mem_wen}, 16'd0);
      cyc();

      // Table-driven fills, no CPU traffic
      for (int v = 0; v < 6; v++) begin
         do_fill(vecs[v].dst, vecs[v].len_raw, vecs[v].val, vecs[v].inc,
                 16'd0, 0, 1'b0, 1'b1, bc);
         check("tbl_count", got_n, vecs[v].exp_n);
         check("tbl_busy", bc, vecs[v].exp_busy);
         if (vecs[v].exp_n > 0) begin
            check("tbl_last", {got_last_a, got_last_d}, {vecs[v].exp_last_a, vecs[v].exp_last_d});
         end
      end

      // CPU takes the port on fill cycles 2 and 5
      do_fill(12'h040, 32'd8, 6'h20, 1'b1, 16'b0000_0000_0001_0010, 0, 1'b0, 1'b1, bc);
      check("contended_busy", bc, 11);

      // Randomized fills with random CPU contention
      for (int r = 0; r < 8; r++) begin
         do_fill(12'($urandom), 32'($urandom_range(0, 40)), 6'($urandom), 1'($urandom),
                 16'd0, 30, 1'b0, 1'b1, bc);
      end

      // Shadow rewrites and a second START while busy leave the fill alone
      do_fill(12'h300, 32'd10, 6'h07, 1'b1, 16'd0, 0, 1'b1, 1'b1, bc);
      check("midcfg_busy", bc, 11);
      do_fill(12'h555, 32'd2, 6'h11, 1'b0, 16'd0, 0, 1'b0, 1'b0, bc);

      // WAIT_VB with vblank already high at START
      vblank = 1'b1;
      cfg_write(2'd0, 32'h0A0);
      cfg_write(2'd1, 32'd2);
      cfg_write(2'd2, 32'h105);
      cfg_write(2'd3, 32'd3);
      @(negedge clk);
      check("vb_remaining", remaining, 2);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("vb_wait_high", {busy, mem_wen}, 2'b10);
         cyc();
      end
      vblank = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("vb_wait_low", {busy, mem_wen}, 2'b10);
         cyc();
      end
      vblank = 1'b1;
      @(negedge clk);
      check("vb_edge_cycle", {busy, mem_wen}, 2'b10);
      cyc();
      @(negedge clk);
      check("vb_write0", {mem_wen, mem_waddr, mem_wdata}, {1'b1, 12'h0A0, 6'h05});
      cyc();
      @(negedge clk);
      check("vb_write1", {mem_wen, mem_waddr, mem_wdata}, {1'b1, 12'h0A1, 6'h06});
      cyc();
      @(negedge clk);
      check("vb_done", {busy, done, mem_wen}, 3'b110);
      cyc();
      @(negedge clk);
      check("vb_idle", busy, 0);
      cyc();
      vblank = 1'b0;

      // ABORT after three writes of a 100-entry fill
      cfg_write(2'd0, 32'h100);
      cfg_write(2'd1, 32'd100);
      cfg_write(2'd2, 32'h3);
      cfg_write(2'd3, 32'd1);
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin
            cfg_wen = 1'b1; cfg_sel = 2'd3; cfg_wdata = 32'h4;
         end
         @(negedge clk);
         check("abort_write", {mem_wen, mem_waddr, mem_wdata}, {1'b1, 12'(12'h100 + i), 6'h03});
         @(posedge clk);
         #1;
         cfg_wen = 1'b0;
      end
      @(negedge clk);
      check("abort_idle", {busy, done, remaining, mem_wen}, 16'd0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         @(negedge clk);
         check("abort_no_done", {busy, done}, 2'b00);
      end
      cyc();
      do_fill(12'h100, 32'd3, 6'h0A, 1'b1, 16'd0, 0, 1'b0, 1'b1, bc);

      // START and ABORT in the same CTRL write
      cfg_write(2'd1, 32'd5);
      cfg_write(2'd3, 32'd5);
      @(negedge clk);
      check("start_abort", {busy, mem_wen}, 2'b00);
      cyc();

      // Reset in the middle of a fill
      cfg_write(2'd0, 32'h200);
      cfg_write(2'd1, 32'd50);
      cfg_write(2'd2, 32'h1);
      cfg_write(2'd3, 32'd1);
      repeat (5) cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      @(negedge clk);
      check("reset_midfill", {busy, done, remaining, mem_wen}, 16'd0);
      cyc();
      // LEN is back to 0: START gives a bare done pulse
      cfg_write(2'd3, 32'd1);
      @(negedge clk);
      check("len0_after_reset", {busy, done, mem_wen}, 3'b110);
      cyc();
      @(negedge clk);
      check("len0_idle", busy, 0);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
